// File: rtl/branch_resolver.sv
// branch_resolver: resolve-side partner of the fetch branch predictor.
// Queues fetch-time predictions in order, checks the oldest against the real
// outcome at resolve, raises a timed flush/redirect on a mispredict and sends
// one-cycle BTB/counter updates for every resolved branch or jump.
module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_valid,
    input  logic [15:0]              fetch_PC,
    input  logic [15:0]              fetch_pred_PC,
    output logic                     fifo_full,
    input  logic                     resolve_valid,
    input  logic                     resolve_is_branch,
    input  logic                     resolve_is_jump,
    input  logic                     resolve_taken,
    input  logic [15:0]              resolve_target,
    output logic                     is_flush,
    output logic [15:0]              redirect_PC,
    output logic                     update_valid,
    output logic [15:0]              update_PC,
    output logic [15:0]              update_target,
    output logic                     update_taken,
    output logic [$clog2(DEPTH):0]   pending_count,
    output logic [15:0]              mispredict_count,
    output logic                     underflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [PW:0]   PONE  = (PW+1)'(1);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] pred;
    } entry_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   fcnt, fcnt_nxt;
    logic [PW:0]     wr_ptr, rd_ptr;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic            run, empty, full, push, pop, underflow_hit;
    logic            take, ctl, mispredict;
    logic [15:0]     actual;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign fifo_full     = full;
    assign pending_count = wr_ptr - rd_ptr;
    assign head          = mem[rd_ptr[PW-1:0]];

    // A pop at full frees the slot being written, so push is allowed then.
    assign run           = (state == RUN);
    assign pop           = resolve_valid && run && !empty;
    assign push          = fetch_valid && run && (!full || pop);
    assign underflow_hit = resolve_valid && run && empty;

    // Non-control entries also go through the compare to catch BTB aliasing.
    assign take       = resolve_is_jump || (resolve_is_branch && resolve_taken);
    assign ctl        = resolve_is_branch || resolve_is_jump;
    assign actual     = take ? resolve_target : head.pc + 16'd1;
    assign mispredict = pop && (actual != head.pred);

    assign is_flush = (state == FLUSH);

    // FSM state and flush-length counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next state: stay in FLUSH for exactly FLUSH_CYCLES cycles
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FLOAD;
                end
            end
            FLUSH: begin
                if (fcnt == '0) state_nxt = RUN;
                else            fcnt_nxt  = fcnt - 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // FIFO pointers; a mispredict squashes everything in flight, including a same-cycle push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE;
            if (pop)  rd_ptr <= rd_ptr + PONE;
        end
    end

    // FIFO storage, no reset needed: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= '{pc: fetch_PC, pred: fetch_pred_PC};
    end

    // Redirect target, predictor update strobe and status counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_PC      <= '0;
            update_valid     <= 1'b0;
            update_PC        <= '0;
            update_target    <= '0;
            update_taken     <= 1'b0;
            mispredict_count <= '0;
            underflow_err    <= 1'b0;
        end else begin
            update_valid <= pop && ctl;
            if (pop && ctl) begin
                update_PC     <= head.pc;
                update_target <= resolve_target;
                update_taken  <= resolve_is_jump || resolve_taken;
            end
            if (mispredict) begin
                redirect_PC <= actual;
                if (mispredict_count != 16'hFFFF)
                    mispredict_count <= mispredict_count + 16'd1;
            end
            if (underflow_hit) underflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a per-cycle vector table covering the
// main resolve/flush/FIFO behaviour, plus a hand sequence for reset mid-flush.
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [15:0] fetch_PC, fetch_pred_PC;
    logic        fifo_full;
    logic        resolve_valid, resolve_is_branch, resolve_is_jump, resolve_taken;
    logic [15:0] resolve_target;
    logic        is_flush;
    logic [15:0] redirect_PC;
    logic        update_valid;
    logic [15:0] update_PC, update_target;
    logic        update_taken;
    logic [2:0]  pending_count;
    logic [15:0] mispredict_count;
    logic        underflow_err;

    int total = 0;
    int bad   = 0;

    branch_resolver #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_PC(fetch_PC), .fetch_pred_PC(fetch_pred_PC),
        .fifo_full(fifo_full),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_is_jump(resolve_is_jump), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .is_flush(is_flush), .redirect_PC(redirect_PC),
        .update_valid(update_valid), .update_PC(update_PC),
        .update_target(update_target), .update_taken(update_taken),
        .pending_count(pending_count), .mispredict_count(mispredict_count),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [15:0] fpc, fpred;
        logic        rv, br, jp, tk;
        logic [15:0] tgt;
        logic        flush;
        logic [15:0] redir;
        logic        uv;
        logic [15:0] upc, utgt;
        logic        utk;
        logic [2:0]  pend;
        logic [15:0] mis;
        logic        under;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(
        input logic fv, input logic [15:0] fpc, input logic [15:0] fpred,
        input logic rv, input logic br, input logic jp, input logic tk, input logic [15:0] tgt,
        input logic flush, input logic [15:0] redir,
        input logic uv, input logic [15:0] upc, input logic [15:0] utgt, input logic utk,
        input logic [2:0] pend, input logic [15:0] mis, input logic under);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.fpred = fpred;
        v.rv = rv; v.br = br; v.jp = jp; v.tk = tk; v.tgt = tgt;
        v.flush = flush; v.redir = redir;
        v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk;
        v.pend = pend; v.mis = mis; v.under = under;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0; fetch_PC = '0; fetch_pred_PC = '0;
        resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_is_jump = 1'b0;
        resolve_taken = 1'b0; resolve_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // expected state after each clock edge; columns:
        //        fv  fpc      fpred    rv br jp tk tgt      | flush redir    uv upc      utgt     utk pend mis under
        tbl[0]  = mk(1, 16'h0010, 16'h0011, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
        tbl[1]  = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[2]  = mk(1, 16'h0020, 16'h0021, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
        // BEQ taken to 0x30, predicted fall-through; same-cycle push is squashed
        tbl[3]  = mk(1, 16'h0099, 16'h009A, 1, 1, 0, 1, 16'h0030, 1, 16'h0030, 1, 16'h0020, 16'h0030, 1, 0, 1, 0);
        // pushes and resolves during flush are ignored (no underflow)
        tbl[4]  = mk(1, 16'h0050, 16'h0051, 1, 0, 0, 0, 16'h0000, 1, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
        tbl[5]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
        tbl[6]  = mk(1, 16'h0040, 16'h0050, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1, 0);
        // BNE taken, correctly predicted
        tbl[7]  = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h0050, 0, 16'h0000, 1, 16'h0040, 16'h0050, 1, 0, 1, 0);
        tbl[8]  = mk(1, 16'h0040, 16'h0050, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1, 0);
        // BNE not taken, predicted taken -> redirect to PC+1
        tbl[9]  = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0050, 1, 16'h0041, 1, 16'h0040, 16'h0050, 0, 0, 2, 0);
        tbl[10] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000, 16'h0000, 0, 0, 2, 0);
        tbl[11] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2, 0);
        // fill to DEPTH
        tbl[12] = mk(1, 16'h0100, 16'h0101, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2, 0);
        tbl[13] = mk(1, 16'h0200, 16'h0201, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2, 2, 0);
        tbl[14] = mk(1, 16'h0300, 16'h0301, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3, 2, 0);
        tbl[15] = mk(1, 16'h0400, 16'h0401, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 4, 2, 0);
        // push at full without pop is dropped
        tbl[16] = mk(1, 16'h0500, 16'h0501, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 4, 2, 0);
        // push + jump resolve at full; jump forces taken=1 even with resolve_taken=0
        tbl[17] = mk(1, 16'h0600, 16'h0601, 1, 0, 1, 0, 16'h0101, 0, 16'h0000, 1, 16'h0100, 16'h0101, 1, 4, 2, 0);
        tbl[18] = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3, 2, 0);
        tbl[19] = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2, 2, 0);
        tbl[20] = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0999, 0, 16'h0000, 1, 16'h0400, 16'h0999, 0, 1, 2, 0);
        // next out must be 0x0600: 0x0500 was dropped
        tbl[21] = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0123, 0, 16'h0000, 1, 16'h0600, 16'h0123, 0, 0, 2, 0);
        // PC wrap: 0xFFFF+1 = 0x0000 matches prediction
        tbl[22] = mk(1, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2, 0);
        tbl[23] = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2, 0);
        // push + resolve at empty: push kept, resolve flagged as underflow
        tbl[24] = mk(1, 16'h0700, 16'h0701, 1, 1, 0, 1, 16'h0777, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2, 1);
        tbl[25] = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2, 1);
        tbl[26] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2, 1);

        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst is_flush", 32'(is_flush), 0);
        chk("rst redirect_PC", 32'(redirect_PC), 0);
        chk("rst update_valid", 32'(update_valid), 0);
        chk("rst pending", 32'(pending_count), 0);
        chk("rst fifo_full", 32'(fifo_full), 0);
        chk("rst mispredict_count", 32'(mispredict_count), 0);
        chk("rst underflow", 32'(underflow_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 27; i++) begin
            fetch_valid = tbl[i].fv; fetch_PC = tbl[i].fpc; fetch_pred_PC = tbl[i].fpred;
            resolve_valid = tbl[i].rv; resolve_is_branch = tbl[i].br;
            resolve_is_jump = tbl[i].jp; resolve_taken = tbl[i].tk; resolve_target = tbl[i].tgt;
            step();
            chk($sformatf("v%0d is_flush", i), 32'(is_flush), 32'(tbl[i].flush));
            if (tbl[i].flush)
                chk($sformatf("v%0d redirect_PC", i), 32'(redirect_PC), 32'(tbl[i].redir));
            chk($sformatf("v%0d update_valid", i), 32'(update_valid), 32'(tbl[i].uv));
            if (tbl[i].uv) begin
                chk($sformatf("v%0d update_PC", i), 32'(update_PC), 32'(tbl[i].upc));
                chk($sformatf("v%0d update_target", i), 32'(update_target), 32'(tbl[i].utgt));
                chk($sformatf("v%0d update_taken", i), 32'(update_taken), 32'(tbl[i].utk));
            end
            chk($sformatf("v%0d pending", i), 32'(pending_count), 32'(tbl[i].pend));
            chk($sformatf("v%0d fifo_full", i), 32'(fifo_full), 32'(tbl[i].pend == 3'd4));
            chk($sformatf("v%0d mispredict_count", i), 32'(mispredict_count), 32'(tbl[i].mis));
            chk($sformatf("v%0d underflow", i), 32'(underflow_err), 32'(tbl[i].under));
        end
        idle();

        // Mispredict with a younger entry queued clears the FIFO; then reset mid-flush.
        fetch_valid = 1'b1; fetch_PC = 16'h0800; fetch_pred_PC = 16'h0801;
        step();
        fetch_PC = 16'h0810; fetch_pred_PC = 16'h0811;
        step();
        chk("seq pending before jump", 32'(pending_count), 2);
        idle();
        resolve_valid = 1'b1; resolve_is_jump = 1'b1; resolve_target = 16'h0900;
        step();
        idle();
        chk("seq jump is_flush", 32'(is_flush), 1);
        chk("seq jump redirect_PC", 32'(redirect_PC), 32'h0900);
        chk("seq jump pending cleared", 32'(pending_count), 0);
        chk("seq jump mispredict_count", 32'(mispredict_count), 3);
        chk("seq jump update_valid", 32'(update_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst is_flush", 32'(is_flush), 0);
        chk("async rst redirect_PC", 32'(redirect_PC), 0);
        chk("async rst update_valid", 32'(update_valid), 0);
        chk("async rst pending", 32'(pending_count), 0);
        chk("async rst mispredict_count", 32'(mispredict_count), 0);
        chk("async rst underflow", 32'(underflow_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post rst is_flush", 32'(is_flush), 0);
        step();
        chk("post rst still idle", 32'(is_flush), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolve-side counterpart of the fetch-stage branch predictor.
- Records every fetch-time prediction in an in-order FIFO. At the resolve stage it pops the oldest entry and compares the prediction with the actual outcome.
- On a mismatch it raises flush/redirect to the pipeline.
- It emits one-cycle update requests (PC, target, taken) back to the predictor's BTB and 2-bit counters.

Parameters:
- DEPTH, 4, in-flight prediction FIFO entries; power of 2, minimum 2.
- FLUSH_CYCLES, 2, number of cycles is_flush stays high after a mispredict; minimum 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fetch_valid  input  1  a fetched instruction's prediction is presented this cycle.
- fetch_PC  input  16  PC of the fetched instruction.
- fetch_pred_PC  input  16  next_PC chosen by the predictor for it.
- fifo_full  output  1  FIFO holds DEPTH entries; fetch must stall.
- resolve_valid  input  1  the oldest in-flight instruction resolves this cycle.
- resolve_is_branch  input  1  resolving instruction is a conditional branch (BNE/BEQ/BGZ/BLZ).
- resolve_is_jump  input  1  resolving instruction is an unconditional jump (JMP/JAL/JPR/JRL).
- resolve_taken  input  1  actual branch condition; ignored for jumps, which are always taken.
- resolve_target  input  16  taken target (PC+Imm or register/jump address).
- is_flush  output  1  squash younger instructions.
- redirect_PC  output  16  correct next PC; valid while is_flush=1.
- update_valid  output  1  one-cycle predictor update strobe.
- update_PC  output  16  PC of the resolved branch/jump.
- update_target  output  16  BTB target to write.
- update_taken  output  1  counter direction, 1 means increment.
- pending_count  output  log2(DEPTH)+1  current FIFO occupancy.
- mispredict_count  output  16  saturating mispredict counter.
- underflow_err  output  1  sticky; resolve_valid was seen with the FIFO empty.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - FIFO emptied; read and write pointers set to 0.
  - State set to RUN.
  - All outputs 0: is_flush, redirect_PC=16'h0000, update_*, pending_count, mispredict_count, underflow_err.
  - Reset asserted mid-flush aborts the flush immediately.
- FIFO storage: each entry is {fetch_PC, fetch_pred_PC}, 32 bits.
  - Push when fetch_valid && state==RUN && (!full || pop this cycle).
  - Pop when resolve_valid && state==RUN && !empty.
  - Simultaneous push and pop is legal at full and at empty: occupancy stays unchanged at full; at empty the push is accepted and the pop is treated as underflow.
  - fetch_valid while full with no pop: push dropped; fifo_full already high.
  - fifo_full and pending_count are combinational from the pointers.
- Actual next PC:
  - actual = (resolve_is_jump || (resolve_is_branch && resolve_taken)) ? resolve_target : entry_PC + 1.
  - 16-bit arithmetic, wraps: 16'hFFFF+1 = 16'h0000.
  - mispredict = (actual != entry_pred_PC).
  - Non-branch, non-jump entries are checked the same way, which catches BTB aliasing.
- Update port, registered, valid 1 cycle after the pop:
  - Issued for every popped branch or jump, whether predicted correctly or not.
  - update_PC = entry_PC; update_target = resolve_target.
  - update_taken = resolve_taken for branches, 1 for jumps.
  - update_valid is a single-cycle pulse; no update for other instructions.
- State machine RUN / FLUSH:
  - RUN -> FLUSH on a pop that mispredicts. In the next cycle: is_flush=1, redirect_PC=actual, FIFO cleared (pushes in that same cycle are discarded), flush counter loaded with FLUSH_CYCLES-1.
  - FLUSH: is_flush held 1 and redirect_PC held. fetch_valid and resolve_valid are ignored, with no underflow flagging. The counter decrements each cycle; at 0 the next state is RUN and is_flush falls.
  - Total is_flush high time is exactly FLUSH_CYCLES cycles.
- mispredict_count increments by 1 per mispredict and saturates at 16'hFFFF.
- underflow_err is set by resolve_valid in RUN with the FIFO empty. It is cleared only by reset. No update or flush results.

Test Plan:
- Reset, then push {PC=0x0010, pred=0x0011}; resolve non-branch -> no flush, update_valid=0, pending_count returns to 0.
- Push {0x0020, 0x0021}; resolve BEQ taken with target 0x0030 -> is_flush=1 for 2 cycles with redirect_PC=0x0030; update {0x0020, 0x0030, taken=1} one cycle after resolve; mispredict_count=1; pushes during the flush ignored.
- Push {0x0040, 0x0050}; resolve BNE taken with target 0x0050 -> no flush; update_valid pulse with taken=1. Then push {0x0040, 0x0050}; resolve not-taken -> flush, redirect_PC=0x0041, update_taken=0.
- Fill 4 entries -> fifo_full=1 and a 5th push is dropped; push and resolve in the same cycle -> accepted, pending_count stays 4, entries pop in FIFO order.
- Entry {0xFFFF, 0x0000}, non-branch -> no mispredict (wrap). resolve_valid on an empty FIFO -> underflow_err=1 and stays 1 until reset.
- Assert reset_n=0 in the middle of a flush -> is_flush=0 asynchronously, FIFO empty, counters cleared.
